scan_frame_processor: RTL

SCAN_FRAME_PROCESSOR -- requirements
Module: scan_frame_processor

---
 rtl/scan_frame_processor_if.sv | 36 +++
 rtl/scan_frame_processor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/scan_frame_processor_if.sv
`default_nettype none
// ============================================================================
// Module   : scan_frame_processor_if
// Purpose  : Byte-stream input and result bus of the scan frame processor.
// Revision : 1.0
// ============================================================================
interface scan_frame_processor_if #(
    parameter int MAX_SAMPLES = 16
);
    logic [7:0]             datain;
    logic                   flashin;
    logic [15:0]            lowest;
    logic [15:0]            highest;
    logic [15:0]            lowest_dist;
    logic [15:0]            highest_dist;
    logic [7:0]             lowest_idx;
    logic [7:0]             highest_idx;
    logic [MAX_SAMPLES-1:0] hitvector;
    logic                   flashout;
    logic                   busy;
    logic                   err;
    logic                   overrun;

    modport master (
        output datain, flashin,
        input  lowest, highest, lowest_dist, highest_dist, lowest_idx, highest_idx,
        input  hitvector, flashout, busy, err, overrun
    );

    modport slave (
        input  datain, flashin,
        output lowest, highest, lowest_dist, highest_dist, lowest_idx, highest_idx,
        output hitvector, flashout, busy, err, overrun
    );
endinterface
`default_nettype wire

// File: rtl/scan_frame_processor.sv
`default_nettype none
// ============================================================================
// Module   : scan_frame_processor
// Purpose  : Parses scan frames, finds min/max samples and interpolates angles.
// Revision : 1.0
// ============================================================================
module scan_frame_processor #(
    parameter int          MAX_SAMPLES = 16,
    parameter logic [15:0] HIT_THRESH  = 16'h0200
) (
    input  wire logic             clock,
    input  wire logic             reset,
    scan_frame_processor_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        SAMP  = 3'd2,
        ANG   = 3'd3,
        DONE  = 3'd4,
        DRAIN = 3'd5
    } state_t;

    localparam logic [7:0] C_MAX_SAMPLES = 8'(MAX_SAMPLES);

    state_t                 r_state, w_state_nxt;
    logic [7:0]             r_len, r_lo_byte, r_idx;
    logic [1:0]             r_hcnt;
    logic                   r_phase;
    logic [15:0]            r_fsa, r_lsa, r_min, r_max;
    logic [7:0]             r_min_idx, r_max_idx;
    logic [MAX_SAMPLES-1:0] r_hits;
    logic [8:0]             r_drain_cnt;
    logic                   r_ang_sel, r_div_run;
    logic [3:0]             r_div_cnt;
    logic [7:0]             r_rem;
    logic [15:0]            r_quo, r_ang_lo;
    logic                   r_err, r_overrun;
    logic [15:0]            r_o_lowest, r_o_highest, r_o_lo_dist, r_o_hi_dist;
    logic [7:0]             r_o_lo_idx, r_o_hi_idx;
    logic [MAX_SAMPLES-1:0] r_o_hits;

    logic [15:0] w_sample, w_d, w_quo_nxt, w_angle;
    logic [7:0]  w_k, w_div, w_rem_nxt;
    logic [23:0] w_prod;
    logic [8:0]  w_rem_shift;
    logic        w_qbit, w_div_last;

    assign w_sample    = {bus.datain, r_lo_byte};
    assign w_d         = r_lsa - r_fsa;
    assign w_k         = r_ang_sel ? r_max_idx : r_min_idx;
    assign w_prod      = 24'(w_d) * 24'(w_k);
    assign w_div       = r_len - 8'd1;
    // Quotient never exceeds D, so the top product byte is already below the
    // divisor and only 16 restoring steps are needed.
    assign w_rem_shift = {r_rem, r_quo[15]};
    assign w_qbit      = (w_rem_shift >= {1'b0, w_div});
    assign w_rem_nxt   = w_qbit ? 8'(w_rem_shift - {1'b0, w_div}) : w_rem_shift[7:0];
    assign w_quo_nxt   = {r_quo[14:0], w_qbit};
    assign w_angle     = r_fsa + ((r_len == 8'd1) ? 16'd0 : w_quo_nxt);
    assign w_div_last  = (r_state == ANG) && r_div_run && (r_div_cnt == 4'd15);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  if (bus.flashin) w_state_nxt = HDR;
            HDR:   if (bus.flashin && r_hcnt == 2'd3) begin
                       if (r_len == 8'd0)               w_state_nxt = IDLE;
                       else if (r_len > C_MAX_SAMPLES)  w_state_nxt = DRAIN;
                       else                             w_state_nxt = SAMP;
                   end
            SAMP:  if (bus.flashin && r_phase && r_idx == r_len - 8'd1) w_state_nxt = ANG;
            ANG:   if (w_div_last && r_ang_sel) w_state_nxt = DONE;
            DONE:  w_state_nxt = IDLE;
            DRAIN: if (bus.flashin && r_drain_cnt == 9'd1) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len       <= '0;  r_lo_byte   <= '0;  r_idx       <= '0;
            r_hcnt      <= '0;  r_phase     <= 1'b0;
            r_fsa       <= '0;  r_lsa       <= '0;  r_min       <= '0;  r_max <= '0;
            r_min_idx   <= '0;  r_max_idx   <= '0;  r_hits      <= '0;
            r_drain_cnt <= '0;  r_ang_sel   <= 1'b0; r_div_run  <= 1'b0;
            r_div_cnt   <= '0;  r_rem       <= '0;  r_quo       <= '0;  r_ang_lo <= '0;
            r_err       <= 1'b0; r_overrun  <= 1'b0;
            r_o_lowest  <= '0;  r_o_highest <= '0;  r_o_lo_dist <= '0;  r_o_hi_dist <= '0;
            r_o_lo_idx  <= '0;  r_o_hi_idx  <= '0;  r_o_hits    <= '0;
        end else begin
            r_err     <= 1'b0;
            r_overrun <= (r_state == ANG || r_state == DONE) && bus.flashin && !r_overrun;
            case (r_state)
                IDLE: if (bus.flashin) begin
                    r_len  <= bus.datain;
                    r_hcnt <= 2'd0;
                end
                HDR: if (bus.flashin) begin
                    r_hcnt <= r_hcnt + 2'd1;
                    case (r_hcnt)
                        2'd0:    r_fsa[7:0]  <= bus.datain;
                        2'd1:    r_fsa[15:8] <= bus.datain;
                        2'd2:    r_lsa[7:0]  <= bus.datain;
                        default: r_lsa[15:8] <= bus.datain;
                    endcase
                    if (r_hcnt == 2'd3) begin
                        r_idx       <= '0;
                        r_phase     <= 1'b0;
                        r_hits      <= '0;
                        r_drain_cnt <= {r_len, 1'b0};
                        r_ang_sel   <= 1'b0;
                        r_div_run   <= 1'b0;
                        if (r_len == 8'd0) r_err <= 1'b1;
                    end
                end
                SAMP: if (bus.flashin) begin
                    if (!r_phase) begin
                        r_lo_byte <= bus.datain;
                        r_phase   <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        r_idx   <= r_idx + 8'd1;
                        // Strict compares keep the earliest index on ties.
                        if (r_idx == 8'd0 || w_sample < r_min) begin
                            r_min     <= w_sample;
                            r_min_idx <= r_idx;
                        end
                        if (r_idx == 8'd0 || w_sample > r_max) begin
                            r_max     <= w_sample;
                            r_max_idx <= r_idx;
                        end
                        for (int i = 0; i < MAX_SAMPLES; i++)
                            if (r_idx == 8'(i)) r_hits[i] <= (w_sample < HIT_THRESH);
                    end
                end
                ANG: begin
                    if (!r_div_run) begin
                        r_rem     <= w_prod[23:16];
                        r_quo     <= w_prod[15:0];
                        r_div_cnt <= '0;
                        r_div_run <= 1'b1;
                    end else begin
                        r_rem     <= w_rem_nxt;
                        r_quo     <= w_quo_nxt;
                        r_div_cnt <= r_div_cnt + 4'd1;
                        if (w_div_last) begin
                            r_div_run <= 1'b0;
                            if (!r_ang_sel) begin
                                r_ang_lo  <= w_angle;
                                r_ang_sel <= 1'b1;
                            end else begin
                                r_o_lowest  <= r_ang_lo;
                                r_o_highest <= w_angle;
                                r_o_lo_dist <= r_min;
                                r_o_hi_dist <= r_max;
                                r_o_lo_idx  <= r_min_idx;
                                r_o_hi_idx  <= r_max_idx;
                                r_o_hits    <= r_hits;
                            end
                        end
                    end
                end
                DRAIN: if (bus.flashin) begin
                    r_drain_cnt <= r_drain_cnt - 9'd1;
                    if (r_drain_cnt == 9'd1) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.lowest       = r_o_lowest;
    assign bus.highest      = r_o_highest;
    assign bus.lowest_dist  = r_o_lo_dist;
    assign bus.highest_dist = r_o_hi_dist;
    assign bus.lowest_idx   = r_o_lo_idx;
    assign bus.highest_idx  = r_o_hi_idx;
    assign bus.hitvector    = r_o_hits;
    assign bus.flashout     = (r_state == DONE);
    assign bus.busy         = (r_state != IDLE);
    assign bus.err          = r_err;
    assign bus.overrun      = r_overrun;
endmodule
`default_nettype wire
